mgnt_req_router: RTL and testbench

- Routes host management transactions on the sys_req bus to one of N_PORTS MAC port controllers, and returns the responses to the host.
- Sits between the system management master and the per-port sys_req interfaces of the MAC tops.
- Serialises transactions: exactly one is in flight at a time.
- Adds per-transaction byte counting, ack/response timeouts and error reporting.

---
 rtl/mgnt_req_router_pkg.sv | 49 ++++
 rtl/mgnt_timeout_cnt.sv | 52 +++++
 rtl/mgnt_req_router.sv | 255 +++++++++++++++++++++++++
 tb/tb_mgnt_req_router.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mgnt_req_router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mgnt_req_router_pkg
//  Description : Shared types and constants for the management request
//                router: bus field widths, FSM state encoding, error codes
//                and a request legality check.
//  Revision    : 1.0 - initial release
// ============================================================================
package mgnt_req_router_pkg;

    localparam int MGNT_PORT_W = 4;
    localparam int MGNT_ADDR_W = 8;
    localparam int MGNT_DATA_W = 8;
    localparam int MGNT_LEN_W  = 4;

    // State encoding
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] WDATA = 3'd2;
    localparam logic [2:0] RDATA = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = IDLE,
        S_REQ   = REQ,
        S_WDATA = WDATA,
        S_RDATA = RDATA,
        S_DONE  = DONE
    } mgnt_state_e;

    // Error codes; anything other than ERR_NONE raises up_err
    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BAD_REQ = 2'd1,
        ERR_ACK_TO  = 2'd2,
        ERR_RESP_TO = 2'd3
    } mgnt_err_e;

    // A request is rejected when it targets a non-existent port or has no bytes
    function automatic logic mgnt_req_is_bad(
        input logic [MGNT_PORT_W-1:0] port,
        input logic [MGNT_LEN_W-1:0]  len,
        input int unsigned            n_ports
    );
        return ({28'd0, port} >= n_ports) || (len == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mgnt_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : mgnt_timeout_cnt
//  Description : Saturating wait counter. Each cycle with en_i counts one
//                waited cycle. clr_i restarts the window; when en_i is also
//                set the clearing cycle itself counts as the first waited
//                cycle, so hit_o rises exactly TIMEOUT cycles after the event.
//  Ports       : clk, rst_n  - clock, async active-low reset
//                clr_i       - restart the count
//                en_i        - count this cycle
//                hit_o       - count has reached TIMEOUT (held while saturated)
//  Revision    : 1.0 - initial release
// ============================================================================
module mgnt_timeout_cnt #(
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    localparam logic [CNT_W-1:0] c_limit = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = en_i ? c_one : '0;
        end else if (en_i && (cnt_q != c_limit)) begin
            // Stops at the limit instead of wrapping
            cnt_d = cnt_q + c_one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == c_limit);

endmodule
`default_nettype wire

// File: rtl/mgnt_req_router.sv
`default_nettype none
// ============================================================================
//  Module      : mgnt_req_router
//  Description : Routes host management transactions to one of N_PORTS MAC
//                port controllers, one transaction in flight at a time, with
//                byte counting, ack/response timeouts and error reporting.
//  Ports       : clk, rstn_sys          - clock, async active-low reset
//                up_req_*               - host request / write data / ack
//                up_resp_*, up_done,
//                up_err                 - read bytes and completion to host
//                sys_req_*              - one-hot request and write data out
//                sys_resp_*             - per-port read bytes in
//  Revision    : 1.0 - initial release
// ============================================================================
module mgnt_req_router
    import mgnt_req_router_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  logic                      clk,
    input  logic                      rstn_sys,
    // Host side
    input  logic                      up_req_valid,
    input  logic                      up_req_wr,
    input  logic [MGNT_PORT_W-1:0]    up_req_port,
    input  logic [MGNT_ADDR_W-1:0]    up_req_addr,
    input  logic [MGNT_LEN_W-1:0]     up_req_len,
    output logic                      up_req_ack,
    input  logic [MGNT_DATA_W-1:0]    up_req_data,
    input  logic                      up_req_data_valid,
    output logic [MGNT_DATA_W-1:0]    up_resp_data,
    output logic                      up_resp_data_valid,
    output logic                      up_done,
    output logic                      up_err,
    // Port side
    output logic [N_PORTS-1:0]        sys_req_valid,
    output logic                      sys_req_wr,
    output logic [MGNT_ADDR_W-1:0]    sys_req_addr,
    input  logic [N_PORTS-1:0]        sys_req_ack,
    output logic [MGNT_DATA_W-1:0]    sys_req_data,
    output logic [N_PORTS-1:0]        sys_req_data_valid,
    input  logic [8*N_PORTS-1:0]      sys_resp_data,
    input  logic [N_PORTS-1:0]        sys_resp_data_valid
);

    // ------------------------------------------------------------------
    // State and latched request
    // ------------------------------------------------------------------
    mgnt_state_e               state_q, state_d;
    mgnt_err_e                 err_q, err_d;
    logic [MGNT_PORT_W-1:0]    port_q;
    logic                      wr_q;
    logic [MGNT_ADDR_W-1:0]    addr_q;
    logic [MGNT_LEN_W-1:0]     len_q;
    logic [MGNT_LEN_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic                      ack_q;

    logic [MGNT_DATA_W-1:0]    sys_req_data_q;
    logic [N_PORTS-1:0]        sys_req_data_valid_q;
    logic [MGNT_DATA_W-1:0]    up_resp_data_q;
    logic                      up_resp_data_valid_q;

    // Control from the next-state process
    logic                      w_accept;
    logic                      w_wbyte;
    logic                      w_rbyte;
    logic                      w_tmo_clr;
    logic                      w_tmo_en;
    logic                      w_tmo_hit;

    // Port selection derived from the latched index
    logic [N_PORTS-1:0]        w_port_onehot;
    logic                      w_sel_ack;
    logic                      w_sel_rvalid;
    logic [MGNT_DATA_W-1:0]    w_sel_rdata;

    genvar gi;
    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_onehot
            assign w_port_onehot[gi] = (port_q == MGNT_PORT_W'(gi));
        end
    endgenerate

    // Only the addressed port's ack and strobes are honoured
    assign w_sel_ack    = |(sys_req_ack & w_port_onehot);
    assign w_sel_rvalid = |(sys_resp_data_valid & w_port_onehot);

    always_comb begin
        w_sel_rdata = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (w_port_onehot[p]) begin
                w_sel_rdata = sys_resp_data[8*p +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Timeout counter
    // ------------------------------------------------------------------
    mgnt_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rstn_sys),
        .clr_i (w_tmo_clr),
        .en_i  (w_tmo_en),
        .hit_o (w_tmo_hit)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        byte_cnt_d = byte_cnt_q;
        w_accept   = 1'b0;
        w_wbyte    = 1'b0;
        w_rbyte    = 1'b0;
        w_tmo_clr  = 1'b0;
        w_tmo_en   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                w_tmo_clr = 1'b1;
                if (up_req_valid) begin
                    w_accept   = 1'b1;
                    // Accept cycle starts the ack wait window
                    w_tmo_en   = 1'b1;
                    byte_cnt_d = '0;
                    if (mgnt_req_is_bad(up_req_port, up_req_len, N_PORTS)) begin
                        state_d = S_DONE;
                        err_d   = ERR_BAD_REQ;
                    end else begin
                        state_d = S_REQ;
                        err_d   = ERR_NONE;
                    end
                end
            end

            S_REQ: begin
                w_tmo_en = 1'b1;
                if (w_sel_ack) begin
                    w_tmo_clr = 1'b1;
                    state_d   = wr_q ? S_WDATA : S_RDATA;
                end else if (w_tmo_hit) begin
                    state_d = S_DONE;
                    err_d   = ERR_ACK_TO;
                end
            end

            S_WDATA: begin
                // Host paces write data, so no timeout here
                if (up_req_data_valid) begin
                    w_wbyte    = 1'b1;
                    byte_cnt_d = byte_cnt_q + MGNT_LEN_W'(1);
                    if (byte_cnt_d == len_q) begin
                        state_d = S_DONE;
                        err_d   = ERR_NONE;
                    end
                end
            end

            S_RDATA: begin
                w_tmo_en = 1'b1;
                if (w_sel_rvalid) begin
                    w_rbyte    = 1'b1;
                    w_tmo_clr  = 1'b1;
                    byte_cnt_d = byte_cnt_q + MGNT_LEN_W'(1);
                    if (byte_cnt_d == len_q) begin
                        state_d = S_DONE;
                        err_d   = ERR_NONE;
                    end
                end else if (w_tmo_hit) begin
                    state_d = S_DONE;
                    err_d   = ERR_RESP_TO;
                end
            end

            S_DONE: begin
                w_tmo_clr = 1'b1;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn_sys) begin
        if (!rstn_sys) begin
            state_q              <= S_IDLE;
            err_q                <= ERR_NONE;
            port_q               <= '0;
            wr_q                 <= 1'b0;
            addr_q               <= '0;
            len_q                <= '0;
            byte_cnt_q           <= '0;
            ack_q                <= 1'b0;
            sys_req_data_q       <= '0;
            sys_req_data_valid_q <= '0;
            up_resp_data_q       <= '0;
            up_resp_data_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            byte_cnt_q <= byte_cnt_d;
            ack_q      <= w_accept;

            if (w_accept) begin
                port_q <= up_req_port;
                wr_q   <= up_req_wr;
                addr_q <= up_req_addr;
                len_q  <= up_req_len;
            end

            sys_req_data_valid_q <= '0;
            if (w_wbyte) begin
                sys_req_data_q       <= up_req_data;
                sys_req_data_valid_q <= w_port_onehot;
            end

            up_resp_data_valid_q <= 1'b0;
            if (w_rbyte) begin
                up_resp_data_q       <= w_sel_rdata;
                up_resp_data_valid_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Request drops in the same cycle the selected port acks
    assign sys_req_valid      = ((state_q == S_REQ) && !w_sel_ack) ? w_port_onehot : '0;
    assign sys_req_wr         = wr_q;
    assign sys_req_addr       = addr_q;
    assign sys_req_data       = sys_req_data_q;
    assign sys_req_data_valid = sys_req_data_valid_q;

    assign up_req_ack         = ack_q;
    assign up_resp_data       = up_resp_data_q;
    assign up_resp_data_valid = up_resp_data_valid_q;
    assign up_done            = (state_q == S_DONE);
    assign up_err             = (state_q == S_DONE) && (err_q != ERR_NONE);

endmodule
`default_nettype wire

// File: tb/tb_mgnt_req_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mgnt_req_router
//  Description : Directed self-checking bench for mgnt_req_router.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mgnt_req_router;

    localparam int NP = 4;
    localparam int TO = 20;
    localparam int CW = 5;

    logic           clk = 1'b0;
    logic           rstn_sys = 1'b0;
    logic           up_req_valid = 1'b0;
    logic           up_req_wr = 1'b0;
    logic [3:0]     up_req_port = '0;
    logic [7:0]     up_req_addr = '0;
    logic [3:0]     up_req_len = '0;
    logic           up_req_ack;
    logic [7:0]     up_req_data = '0;
    logic           up_req_data_valid = 1'b0;
    logic [7:0]     up_resp_data;
    logic           up_resp_data_valid;
    logic           up_done;
    logic           up_err;
    logic [NP-1:0]  sys_req_valid;
    logic           sys_req_wr;
    logic [7:0]     sys_req_addr;
    logic [NP-1:0]  sys_req_ack = '0;
    logic [7:0]     sys_req_data;
    logic [NP-1:0]  sys_req_data_valid;
    logic [8*NP-1:0] sys_resp_data = '0;
    logic [NP-1:0]  sys_resp_data_valid = '0;

    int checks = 0;
    int errors = 0;

    mgnt_req_router #(
        .N_PORTS (NP),
        .TIMEOUT (TO),
        .CNT_W   (CW)
    ) dut (
        .clk                 (clk),
        .rstn_sys            (rstn_sys),
        .up_req_valid        (up_req_valid),
        .up_req_wr           (up_req_wr),
        .up_req_port         (up_req_port),
        .up_req_addr         (up_req_addr),
        .up_req_len          (up_req_len),
        .up_req_ack          (up_req_ack),
        .up_req_data         (up_req_data),
        .up_req_data_valid   (up_req_data_valid),
        .up_resp_data        (up_resp_data),
        .up_resp_data_valid  (up_resp_data_valid),
        .up_done             (up_done),
        .up_err              (up_err),
        .sys_req_valid       (sys_req_valid),
        .sys_req_wr          (sys_req_wr),
        .sys_req_addr        (sys_req_addr),
        .sys_req_ack         (sys_req_ack),
        .sys_req_data        (sys_req_data),
        .sys_req_data_valid  (sys_req_data_valid),
        .sys_resp_data       (sys_resp_data),
        .sys_resp_data_valid (sys_resp_data_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic req(input logic wr, input logic [3:0] port, input logic [7:0] addr,
                       input logic [3:0] len);
        up_req_valid = 1'b1;
        up_req_wr    = wr;
        up_req_port  = port;
        up_req_addr  = addr;
        up_req_len   = len;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_ack",   up_req_ack, 0);
        chk("rst_done",  {up_done, up_err}, 0);
        chk("rst_sreq",  {sys_req_valid, sys_req_data_valid, sys_req_wr}, 0);
        chk("rst_addr",  sys_req_addr, 0);
        chk("rst_resp",  {up_resp_data_valid, up_resp_data}, 0);
        rstn_sys = 1'b1;
        step();
        chk("idle_quiet", {up_req_ack, up_done, sys_req_valid}, 0);

        // ---------------- write: port 2, addr 0x10, len 3 ----------------
        req(1'b1, 4'd2, 8'h10, 4'd3);
        step();
        chk("wr_ack",   up_req_ack, 1);
        chk("wr_valid", sys_req_valid, 4'b0100);
        chk("wr_flag",  sys_req_wr, 1);
        chk("wr_addr",  sys_req_addr, 8'h10);
        up_req_valid = 1'b0;
        step();
        chk("wr_ack_pulse", up_req_ack, 0);
        sys_req_ack = 4'b1000;        // foreign ack must be ignored
        #1;
        chk("wr_foreign_ack_comb", sys_req_valid, 4'b0100);
        step();
        chk("wr_foreign_ack", sys_req_valid, 4'b0100);
        sys_req_ack = '0;
        step();
        step();
        sys_req_ack = 4'b0100;
        #1;
        chk("wr_valid_drop", sys_req_valid, 4'b0000);
        step();
        sys_req_ack = '0;
        chk("wr_in_wdata", {sys_req_valid, up_done}, 0);
        up_req_data = 8'hA1;
        up_req_data_valid = 1'b1;
        step();
        chk("wr_b0", {sys_req_data_valid, sys_req_data}, {4'b0100, 8'hA1});
        chk("wr_b0_nodone", up_done, 0);
        up_req_data = 8'hB2;
        step();
        chk("wr_b1", {sys_req_data_valid, sys_req_data}, {4'b0100, 8'hB2});
        up_req_data = 8'hC3;
        step();
        chk("wr_b2", {sys_req_data_valid, sys_req_data}, {4'b0100, 8'hC3});
        chk("wr_done", {up_done, up_err}, 2'b10);
        up_req_data = 8'hD4;          // byte beyond len
        step();
        chk("wr_extra_byte", sys_req_data_valid, 0);
        chk("wr_done_pulse", up_done, 0);
        up_req_data_valid = 1'b0;

        // ---------------- read: port 1, len 2, port 3 chatter ----------------
        req(1'b0, 4'd1, 8'h22, 4'd2);
        step();
        chk("rd_ack",   {up_req_ack, sys_req_valid, sys_req_wr}, {1'b1, 4'b0010, 1'b0});
        chk("rd_addr",  sys_req_addr, 8'h22);
        up_req_valid = 1'b0;
        sys_req_ack = 4'b0010;
        #1;
        chk("rd_valid_drop", sys_req_valid, 0);
        step();
        sys_req_ack = '0;
        sys_resp_data = {8'hFF, 8'h00, 8'h5A, 8'h00};
        sys_resp_data_valid = 4'b1010;
        step();
        chk("rd_b0", {up_resp_data_valid, up_resp_data}, {1'b1, 8'h5A});
        sys_resp_data = {8'hFF, 8'h00, 8'h6B, 8'h00};
        step();
        chk("rd_b1", {up_resp_data_valid, up_resp_data}, {1'b1, 8'h6B});
        chk("rd_done", {up_done, up_err}, 2'b10);
        sys_resp_data = {8'hFF, 8'h00, 8'h77, 8'h00};
        step();
        chk("rd_extra_byte", up_resp_data_valid, 0);
        sys_resp_data_valid = '0;

        // ---------------- illegal requests ----------------
        req(1'b1, 4'd7, 8'h01, 4'd2);
        step();
        chk("bad_port", {up_req_ack, up_done, up_err, sys_req_valid}, {3'b111, 4'b0000});
        up_req_valid = 1'b0;
        step();
        chk("bad_port_after", {up_req_ack, up_done, sys_req_valid}, 0);
        req(1'b0, 4'd0, 8'h02, 4'd0);
        step();
        chk("bad_len", {up_req_ack, up_done, up_err, sys_req_valid}, {3'b111, 4'b0000});
        up_req_valid = 1'b0;
        step();

        // ---------------- ack timeout ----------------
        req(1'b0, 4'd0, 8'h30, 4'd1);
        step();                                   // REQ entry
        chk("to_ack", {up_req_ack, sys_req_valid}, {1'b1, 4'b0001});
        up_req_valid = 1'b0;
        bad = 1'b0;
        for (int k = 1; k < TO; k++) begin
            step();
            if (sys_req_valid !== 4'b0001 || up_done !== 1'b0) bad = 1'b1;
        end
        chk("to_hold", bad, 0);
        step();                                   // TIMEOUT cycles after entry
        chk("to_done", {up_done, up_err, sys_req_valid}, {2'b11, 4'b0000});
        step();

        // ---------------- response timeout: len 4, only 2 bytes ----------------
        req(1'b0, 4'd3, 8'h40, 4'd4);
        step();
        up_req_valid = 1'b0;
        sys_req_ack = 4'b1000;
        step();                                   // RDATA entry
        sys_req_ack = '0;
        sys_resp_data = {8'h11, 24'h0};
        sys_resp_data_valid = 4'b1000;
        step();
        chk("rto_b0", {up_resp_data_valid, up_resp_data}, {1'b1, 8'h11});
        sys_resp_data = {8'h22, 24'h0};
        step();
        chk("rto_b1", {up_resp_data_valid, up_resp_data}, {1'b1, 8'h22});
        sys_resp_data_valid = '0;
        bad = 1'b0;
        for (int k = 1; k < TO; k++) begin
            step();
            if (up_done !== 1'b0 || up_resp_data_valid !== 1'b0) bad = 1'b1;
        end
        chk("rto_hold", bad, 0);
        step();
        chk("rto_done", {up_done, up_err, up_resp_data_valid}, 3'b110);
        sys_resp_data = {8'h33, 24'h0};
        sys_resp_data_valid = 4'b1000;            // late byte must be dropped
        step();
        chk("rto_late", {up_resp_data_valid, up_done}, 0);
        sys_resp_data_valid = '0;

        // ---------------- reset during WDATA ----------------
        req(1'b1, 4'd0, 8'h55, 4'd3);
        step();
        up_req_valid = 1'b0;
        sys_req_ack = 4'b0001;
        step();
        sys_req_ack = '0;
        up_req_data = 8'h99;
        up_req_data_valid = 1'b1;
        step();
        chk("mid_b0", sys_req_data_valid, 4'b0001);
        up_req_data_valid = 1'b0;
        rstn_sys = 1'b0;
        #1;
        chk("mid_rst_strobes", {sys_req_data_valid, sys_req_valid, up_resp_data_valid}, 0);
        chk("mid_rst_regs", {sys_req_wr, sys_req_addr, sys_req_data}, 0);
        chk("mid_rst_done", {up_done, up_err, up_req_ack}, 0);
        step();
        rstn_sys = 1'b1;
        step();
        chk("post_rst_idle", {up_done, sys_req_valid}, 0);
        req(1'b1, 4'd1, 8'h66, 4'd1);
        step();
        chk("post_rst_ack", {up_req_ack, sys_req_valid, sys_req_addr}, {1'b1, 4'b0010, 8'h66});
        up_req_valid = 1'b0;
        sys_req_ack = 4'b0010;
        step();
        sys_req_ack = '0;
        up_req_data = 8'hE7;
        up_req_data_valid = 1'b1;
        step();
        up_req_data_valid = 1'b0;
        chk("post_rst_byte", {sys_req_data_valid, sys_req_data}, {4'b0010, 8'hE7});
        chk("post_rst_done", {up_done, up_err}, 2'b10);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
